dmem_responder: RTL and testbench

Memory-side responder for the core's data-memory port. It accepts one load/store request at a time over a valid/ready handshake and performs the access with programmable wait-state latency. Stores write bytes, halfwords or words into an internal word-organised RAM. Loads return a sign- or zero-extended result over a second valid/ready channel. It is the target end of the EX/MEM access path and replaces the zero-latency memory for stall and back-pressure testing.

---
 rtl/mem_pkg.sv | 38 +++
 rtl/mem_lane_align.sv | 76 +++++++
 rtl/dmem_responder.sv | 138 +++++++++++++
 tb/tb_dmem_responder.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder.
//   - RV32I load/store funct3 encodings
//   - responder FSM state type
//   - access-size type plus a decoder from funct3
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } size_t;

  // Undefined encodings (011, 110, 111) fall through to word size.
  function automatic size_t f3_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return SZ_B;
      F3_H, F3_HU: return SZ_H;
      default:     return SZ_W;
    endcase
  endfunction

  function automatic logic f3_undefined(input logic [2:0] f3);
    return !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering for one 32-bit word access.
// Ports:
//   funct3    - RV32I load/store funct3
//   addr_lo   - byte offset within the word (addr[1:0])
//   wdata     - right-aligned store data
//   rword     - word read from RAM
//   be        - byte enables for stores
//   wdata_sh  - store data replicated onto the addressed lanes
//   rdata_ext - load result, shifted and sign/zero-extended
//   misalign  - access must be rejected (only when MISALIGN_TRAP_EN is defined;
//               otherwise constant 0)
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata_ext,
  output logic        misalign
);

  size_t       size;
  logic [1:0]  off;
  logic [31:0] shifted;

  assign size = f3_size(funct3);

  always_comb begin
    be       = '0;
    wdata_sh = '0;
    off      = '0;
    case (size)
      SZ_B: begin
        be       = 4'b0001 << addr_lo;
        wdata_sh = {4{wdata[7:0]}};
        off      = addr_lo;
      end
      SZ_H: begin
        // addr[0] is dropped: a halfword always sits on an even lane pair.
        be       = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_sh = {2{wdata[15:0]}};
        off      = {addr_lo[1], 1'b0};
      end
      default: begin
        be       = 4'b1111;
        wdata_sh = wdata;
        off      = 2'b00;
      end
    endcase
  end

  assign shifted = rword >> {off, 3'b000};

  always_comb begin
    rdata_ext = shifted;
    case (size)
      SZ_B:    rdata_ext = funct3[2] ? {24'h0, shifted[7:0]}
                                     : {{24{shifted[7]}}, shifted[7:0]};
      SZ_H:    rdata_ext = funct3[2] ? {16'h0, shifted[15:0]}
                                     : {{16{shifted[15]}}, shifted[15:0]};
      default: rdata_ext = shifted;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  assign misalign = ((size == SZ_H) && addr_lo[0])
                 || ((size == SZ_W) && (addr_lo != 2'b00))
                 || f3_undefined(funct3);
`else
  assign misalign = 1'b0;
`endif

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the core's data-memory port.
// Accepts one load/store at a time (req valid/ready), waits LATENCY cycles,
// performs the access on an internal word RAM and returns the result on the
// rsp valid/ready channel.
// Parameters: DEPTH_WORDS (power of two, >= 2), LATENCY (>= 1).
// Ports:
//   clk, rst (synchronous, active-low)
//   req_valid/req_ready, req_we, req_funct3, req_addr, req_wdata - request
//   rsp_valid/rsp_ready, rsp_rdata, rsp_err                      - response
// Build option: MISALIGN_TRAP_EN rejects misaligned/undefined accesses with
// rsp_err = 1; without it rsp_err is always 0.
module dmem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          we_q;
  logic [2:0]    f3_q;
  logic [AW-1:0] idx_q;
  logic [1:0]    lo_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;
  logic          err_q;

  logic [31:0]   mem [DEPTH_WORDS];

  logic          accept;
  logic          access;
  logic [3:0]    be;
  logic [31:0]   wdata_sh;
  logic [31:0]   rdata_ext;
  logic          misalign;
  logic          unused_addr;

  // Address bits above the RAM index wrap away.
  assign unused_addr = ^req_addr[31:AW+2];

  assign accept = req_valid && req_ready;
  assign access = (state_q == WAIT) && (cnt_q == '0);

  mem_lane_align u_align (
    .funct3    (f3_q),
    .addr_lo   (lo_q),
    .wdata     (wdata_q),
    .rword     (mem[idx_q]),
    .be        (be),
    .wdata_sh  (wdata_sh),
    .rdata_ext (rdata_ext),
    .misalign  (misalign)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      idx_q   <= '0;
      lo_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        idx_q   <= req_addr[2 +: AW];
        lo_q    <= req_addr[1:0];
        wdata_q <= req_wdata;
      end
      if (access) begin
        rdata_q <= (we_q || misalign) ? '0 : rdata_ext;
        err_q   <= misalign;
      end
    end
  end

  // RAM is not reset; a store still waiting when rst falls is dropped.
  always_ff @(posedge clk) begin
    if (rst && access && we_q && !misalign) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[idx_q][8*i +: 8] <= wdata_sh[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          cnt_d   = CW'(LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - CW'(1);
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == RESP);
    rsp_rdata = rdata_q;
    rsp_err   = err_q;
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int unsigned DEPTH_WORDS = 1024;
  localparam int unsigned LATENCY     = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

  dmem_responder #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .LATENCY     (LATENCY)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request with rsp_ready high; returns the response and checks
  // the accept-to-valid latency and that req_ready comes back after handshake.
  task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rd, output logic er);
    int n;
    chk("req_ready_idle", {31'h0, req_ready}, 32'h1);
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", 32'(n), LATENCY);
    rd = rsp_rdata;
    er = rsp_err;
    @(posedge clk); #1;
    chk("req_ready_after_hs", {31'h0, req_ready}, 32'h1);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          n;

    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err",   {31'h0, rsp_err},   32'h0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Word write then read
    access(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, er);
    chk("sw_rdata_zero", rd, 32'h0);
    chk("sw_err", {31'h0, er}, 32'h0);
    access(1'b0, 3'b010, 32'h10, 32'h0, rd, er);
    chk("lw_10", rd, 32'hDEADBEEF);
    chk("lw_10_err", {31'h0, er}, 32'h0);

    // Byte and half extension
    access(1'b1, 3'b010, 32'h20, 32'h0, rd, er);
    access(1'b1, 3'b000, 32'h21, 32'h80, rd, er);
    access(1'b0, 3'b000, 32'h21, 32'h0, rd, er);
    chk("lb_21", rd, 32'hFFFFFF80);
    access(1'b0, 3'b100, 32'h21, 32'h0, rd, er);
    chk("lbu_21", rd, 32'h00000080);
    access(1'b0, 3'b100, 32'h20, 32'h0, rd, er);
    chk("lbu_20", rd, 32'h00000000);
    access(1'b1, 3'b001, 32'h22, 32'h8001, rd, er);
    access(1'b0, 3'b001, 32'h22, 32'h0, rd, er);
    chk("lh_22", rd, 32'hFFFF8001);
    access(1'b0, 3'b101, 32'h22, 32'h0, rd, er);
    chk("lhu_22", rd, 32'h00008001);
    access(1'b0, 3'b000, 32'h23, 32'h0, rd, er);
    chk("lb_23", rd, 32'hFFFFFF80);
    access(1'b0, 3'b010, 32'h20, 32'h0, rd, er);
    chk("lw_20", rd, 32'h80018000);

    // Back-pressure: hold rsp_ready low for 5 cycles; a competing store is ignored
    rsp_ready = 1'b0;
    req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; req_valid = 1'b1;
    @(posedge clk); #1;
    req_we = 1'b1; req_wdata = 32'h0;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_latency", 32'(n), LATENCY);
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", {31'h0, rsp_valid}, 32'h1);
      chk("bp_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
      chk("bp_rsp_err",   {31'h0, rsp_err}, 32'h0);
      chk("bp_req_ready", {31'h0, req_ready}, 32'h0);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_req_ready", {31'h0, req_ready}, 32'h1);
    chk("bp_release_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    access(1'b0, 3'b010, 32'h10, 32'h0, rd, er);
    chk("bp_store_ignored", rd, 32'hDEADBEEF);

    // Address wrap
    access(1'b1, 3'b010, 32'h1000, 32'h12345678, rd, er);
    access(1'b0, 3'b010, 32'h0, 32'h0, rd, er);
    chk("wrap_lw_0", rd, 32'h12345678);

    // Reset in WAIT drops the pending store
    access(1'b1, 3'b010, 32'h40, 32'h0, rd, er);
    access(1'b0, 3'b010, 32'h10, 32'h0, rd, er);
    req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h40; req_wdata = 32'hFFFFFFFF;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rw_in_wait", {31'h0, req_ready}, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rw_req_ready", {31'h0, req_ready}, 32'h1);
    chk("rw_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rw_rsp_rdata", rsp_rdata, 32'h0);
    chk("rw_rsp_err",   {31'h0, rsp_err}, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    access(1'b0, 3'b010, 32'h40, 32'h0, rd, er);
    chk("rw_lw_40", rd, 32'h0);

    // Misaligned and undefined-funct3 accesses
    access(1'b1, 3'b010, 32'h40, 32'hCAFEF00D, rd, er);
`ifdef MISALIGN_TRAP_EN
    access(1'b0, 3'b010, 32'h42, 32'h0, rd, er);
    chk("mis_lw_rdata", rd, 32'h0);
    chk("mis_lw_err", {31'h0, er}, 32'h1);
    access(1'b1, 3'b001, 32'h41, 32'hABCD, rd, er);
    chk("mis_sh_err", {31'h0, er}, 32'h1);
    access(1'b0, 3'b010, 32'h40, 32'h0, rd, er);
    chk("mis_sh_unchanged", rd, 32'hCAFEF00D);
    chk("mis_aligned_err", {31'h0, er}, 32'h0);
    access(1'b1, 3'b011, 32'h10, 32'h11223344, rd, er);
    chk("undef_f3_err", {31'h0, er}, 32'h1);
    access(1'b0, 3'b010, 32'h10, 32'h0, rd, er);
    chk("undef_f3_nowrite", rd, 32'hDEADBEEF);
`else
    access(1'b0, 3'b010, 32'h42, 32'h0, rd, er);
    chk("mis_lw_rdata", rd, 32'hCAFEF00D);
    chk("mis_lw_err", {31'h0, er}, 32'h0);
    access(1'b1, 3'b001, 32'h41, 32'hABCD, rd, er);
    chk("mis_sh_err", {31'h0, er}, 32'h0);
    access(1'b0, 3'b010, 32'h40, 32'h0, rd, er);
    chk("mis_sh_lowhalf", rd, 32'hCAFEABCD);
    access(1'b0, 3'b001, 32'h41, 32'h0, rd, er);
    chk("mis_lh_41", rd, 32'hFFFFABCD);
    access(1'b1, 3'b011, 32'h13, 32'h11223344, rd, er);
    chk("undef_f3_err", {31'h0, er}, 32'h0);
    access(1'b0, 3'b010, 32'h10, 32'h0, rd, er);
    chk("undef_f3_word", rd, 32'h11223344);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
